// File: rtl/hist_mem_arbiter.sv
// hist_mem_arbiter: shares the single-port 128-bit histogram memory between the
// vector core (write-back/load path) and the host readout port. Round-robin
// arbitration, host burst lock with a beat limit, and core anti-starvation.
module hist_mem_arbiter #(
    parameter int DW        = 128,
    parameter int AW        = 13,
    parameter int MAX_BURST = 8,
    parameter int MAX_WAIT  = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_stall,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    input  logic          host_req,
    input  logic          host_lock,
    input  logic [AW-1:0] host_addr,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [BW-1:0] BURST_LIMIT = BW'(MAX_BURST);
    localparam logic [WW-1:0] WAIT_LIMIT  = WW'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_CORE       = 2'd1,
        S_HOST_BURST = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_last_host;
    logic [BW-1:0] r_burst_cnt;
    logic [WW-1:0] r_wait_cnt;
    logic [AW-1:0] r_addr_hold;
    logic [DW-1:0] r_wdata_hold;
    logic          r_rd_valid;
    logic          r_rd_host;
    logic [DW-1:0] r_core_rdata;
    logic [DW-1:0] r_host_rdata;

    logic          w_core_gnt;
    logic          w_host_gnt;
    logic          w_burst_full;
    logic          w_burst_exit;

    // Grant decision: a locked host burst keeps the port until lock/request drop,
    // the beat limit is hit, or the core has waited long enough; otherwise
    // round-robin against the last owner. Reset forces every grant low at once.
    always_comb begin
        w_core_gnt   = 1'b0;
        w_host_gnt   = 1'b0;
        w_burst_full = (r_burst_cnt == BURST_LIMIT);
        w_burst_exit = !host_lock || !host_req || w_burst_full || (r_wait_cnt == WAIT_LIMIT);
        if (!reset) begin
            if (r_state == S_HOST_BURST) begin
                if (!w_burst_exit) begin
                    w_host_gnt = 1'b1;
                end else if (core_req) begin
                    w_core_gnt = 1'b1;
                end else if (host_req && !w_burst_full) begin
                    w_host_gnt = 1'b1;
                end
            end else if (core_req && host_req) begin
                w_core_gnt = r_last_host;
                w_host_gnt = !r_last_host;
            end else begin
                w_core_gnt = core_req;
                w_host_gnt = host_req;
            end
        end
    end

    assign core_gnt   = w_core_gnt;
    assign host_gnt   = w_host_gnt;
    assign core_stall = core_req && !w_core_gnt && !reset;

    // The memory port follows the grant; with no grant the address and data hold.
    assign mem_we    = w_core_gnt && core_we;
    assign mem_addr  = w_core_gnt ? core_addr : (w_host_gnt ? host_addr : r_addr_hold);
    assign mem_wdata = w_core_gnt ? core_wdata : r_wdata_hold;

    // Arbitration state, last owner, burst beat count (counts the grant that opened
    // the burst) and the saturating core wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_last_host <= 1'b1;
            r_burst_cnt <= '0;
            r_wait_cnt  <= '0;
        end else begin
            if (w_core_gnt) begin
                r_wait_cnt <= '0;
            end else if (core_stall && r_wait_cnt != WAIT_LIMIT) begin
                r_wait_cnt <= r_wait_cnt + WW'(1);
            end
            if (w_core_gnt) begin
                r_last_host <= 1'b0;
            end else if (w_host_gnt) begin
                r_last_host <= 1'b1;
            end
            case (r_state)
                S_HOST_BURST: begin
                    if (w_burst_exit) begin
                        r_state     <= S_IDLE;
                        r_burst_cnt <= '0;
                    end else begin
                        r_burst_cnt <= r_burst_cnt + BW'(1);
                    end
                end
                default: begin
                    if (w_host_gnt && host_lock) begin
                        r_state     <= S_HOST_BURST;
                        r_burst_cnt <= BW'(1);
                    end else begin
                        r_state     <= w_core_gnt ? S_CORE : S_IDLE;
                        r_burst_cnt <= '0;
                    end
                end
            endcase
        end
    end

    // Remember the last driven address/data so ungranted cycles hold them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr_hold  <= '0;
            r_wdata_hold <= '0;
        end else if (w_core_gnt) begin
            r_addr_hold  <= core_addr;
            r_wdata_hold <= core_wdata;
        end else if (w_host_gnt) begin
            r_addr_hold  <= host_addr;
        end
    end

    // One-cycle read tag {valid, owner} lining up with the memory read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_host  <= 1'b0;
        end else begin
            r_rd_valid <= (w_core_gnt && !core_we) || w_host_gnt;
            r_rd_host  <= w_host_gnt;
        end
    end

    assign core_rvalid = r_rd_valid && !r_rd_host;
    assign host_rvalid = r_rd_valid && r_rd_host;

    // Capture returned data so each requester's rdata holds between returns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_core_rdata <= '0;
            r_host_rdata <= '0;
        end else begin
            if (core_rvalid) begin
                r_core_rdata <= mem_rdata;
            end
            if (host_rvalid) begin
                r_host_rdata <= mem_rdata;
            end
        end
    end

    assign core_rdata = core_rvalid ? mem_rdata : r_core_rdata;
    assign host_rdata = host_rvalid ? mem_rdata : r_host_rdata;

endmodule

// File: tb/tb_hist_mem_arbiter.sv
// tb_hist_mem_arbiter: directed scenarios plus constrained-random traffic for
// hist_mem_arbiter, with a behavioural memory and a cycle-level arbitration model.
module tb_hist_mem_arbiter;

    localparam int MAX_BURST = 8;
    localparam int MAX_WAIT  = 4;

    logic         clk;
    logic         reset;
    logic         core_req;
    logic         core_we;
    logic [12:0]  core_addr;
    logic [127:0] core_wdata;
    logic         core_gnt;
    logic         core_stall;
    logic         core_rvalid;
    logic [127:0] core_rdata;
    logic         host_req;
    logic         host_lock;
    logic [12:0]  host_addr;
    logic         host_gnt;
    logic         host_rvalid;
    logic [127:0] host_rdata;
    logic [12:0]  mem_addr;
    logic         mem_we;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;

    int assertCount = 0;
    int failCount   = 0;

    // Arbitration model state, kept as plain counters and flags.
    bit           mLocked;
    int           mBeats;
    int           mWait;
    bit           mLastCore;
    bit           pendValid;
    bit           pendHost;
    logic [127:0] pendData;
    logic [127:0] expCoreRdata;
    logic [127:0] expHostRdata;
    logic [127:0] expWdataHold;
    logic [12:0]  expAddrHold;
    logic [127:0] shadow [0:8191];
    bit           predCore;
    bit           predHost;
    bit           predStall;

    logic [127:0] memArray [0:8191];

    hist_mem_arbiter #(
        .DW(128), .AW(13), .MAX_BURST(MAX_BURST), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .host_req(host_req), .host_lock(host_lock), .host_addr(host_addr),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous memory with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_we) memArray[mem_addr] <= mem_wdata;
        mem_rdata <= mem_we ? mem_wdata : memArray[mem_addr];
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mLocked      = 1'b0;
        mBeats       = 0;
        mWait        = 0;
        mLastCore    = 1'b0;
        pendValid    = 1'b0;
        pendHost     = 1'b0;
        pendData     = '0;
        expCoreRdata = '0;
        expHostRdata = '0;
        expWdataHold = '0;
        expAddrHold  = '0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_core_gnt"},    128'(core_gnt),    '0);
        checkOutput({tag, "_host_gnt"},    128'(host_gnt),    '0);
        checkOutput({tag, "_core_stall"},  128'(core_stall),  '0);
        checkOutput({tag, "_mem_we"},      128'(mem_we),      '0);
        checkOutput({tag, "_mem_addr"},    128'(mem_addr),    '0);
        checkOutput({tag, "_mem_wdata"},   mem_wdata,         '0);
        checkOutput({tag, "_core_rvalid"}, 128'(core_rvalid), '0);
        checkOutput({tag, "_host_rvalid"}, 128'(host_rvalid), '0);
        checkOutput({tag, "_core_rdata"},  core_rdata,        '0);
        checkOutput({tag, "_host_rdata"},  host_rdata,        '0);
    endtask

    // Predict this cycle's grants and returns from the arbitration rules, compare
    // every output, then advance the model past the coming clock edge.
    task automatic checkCycle(input string tag);
        bit gC, gH, ending;
        gC = 1'b0;
        gH = 1'b0;
        ending = 1'b0;
        if (mLocked) begin
            ending = !host_lock || !host_req || mBeats >= MAX_BURST || mWait >= MAX_WAIT;
            if (!ending) gH = 1'b1;
            else if (core_req) gC = 1'b1;
            else if (host_req && mBeats < MAX_BURST) gH = 1'b1;
        end else if (core_req && host_req) begin
            if (mLastCore) gH = 1'b1;
            else gC = 1'b1;
        end else begin
            gC = core_req;
            gH = host_req;
        end
        if (pendValid && !pendHost) expCoreRdata = pendData;
        if (pendValid && pendHost)  expHostRdata = pendData;

        checkOutput({tag, "_core_gnt"},    128'(core_gnt),    128'(gC));
        checkOutput({tag, "_host_gnt"},    128'(host_gnt),    128'(gH));
        checkOutput({tag, "_core_stall"},  128'(core_stall),  128'(core_req && !gC));
        checkOutput({tag, "_mem_we"},      128'(mem_we),      128'(gC && core_we));
        checkOutput({tag, "_mem_addr"},    128'(mem_addr),    128'(gC ? core_addr : (gH ? host_addr : expAddrHold)));
        checkOutput({tag, "_mem_wdata"},   mem_wdata,         gC ? core_wdata : expWdataHold);
        checkOutput({tag, "_core_rvalid"}, 128'(core_rvalid), 128'(pendValid && !pendHost));
        checkOutput({tag, "_host_rvalid"}, 128'(host_rvalid), 128'(pendValid && pendHost));
        checkOutput({tag, "_core_rdata"},  core_rdata,        expCoreRdata);
        checkOutput({tag, "_host_rdata"},  host_rdata,        expHostRdata);

        if (gC) begin
            expAddrHold  = core_addr;
            expWdataHold = core_wdata;
        end else if (gH) begin
            expAddrHold = host_addr;
        end
        pendValid = (gC && !core_we) || gH;
        pendHost  = gH;
        pendData  = gC ? shadow[core_addr] : shadow[host_addr];
        if (gC && core_we) shadow[core_addr] = core_wdata;
        if (gC) mWait = 0;
        else if (core_req && mWait < MAX_WAIT) mWait++;
        if (gC) mLastCore = 1'b1;
        else if (gH) mLastCore = 1'b0;
        if (mLocked) begin
            if (ending) begin
                mLocked = 1'b0;
                mBeats  = 0;
            end else begin
                mBeats++;
            end
        end else if (gH && host_lock) begin
            mLocked = 1'b1;
            mBeats  = 1;
        end
        predCore  = gC;
        predHost  = gH;
        predStall = core_req && !gC;
    endtask

    task automatic applyStimulus(input string tag, input logic cReq, input logic cWe, input logic [12:0] cAddr,
                                 input logic [127:0] cWdata, input logic hReq, input logic hLock,
                                 input logic [12:0] hAddr);
        @(negedge clk);
        core_req   = cReq;
        core_we    = cWe;
        core_addr  = cAddr;
        core_wdata = cWdata;
        host_req   = hReq;
        host_lock  = hLock;
        host_addr  = hAddr;
        #1;
        checkCycle(tag);
    endtask

    // Directed scenarios followed by random traffic, all in one linear sequence.
    initial begin
        int remaining;
        int stallCount;
        int coreGrantAt;
        int hostGrants;
        logic         rCReq, rCWe, rHReq, rHLock;
        logic [12:0]  rCAddr, rHAddr;
        logic [127:0] rCWdata;

        reset = 1'b1;
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        host_req = 1'b0; host_lock = 1'b0; host_addr = '0;
        modelReset();
        #12;
        checkResetOutputs("por");
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] preload addresses 0..15 through the core port");
        for (int i = 0; i < 16; i++) begin
            applyStimulus("preload", 1'b1, 1'b1, 13'(i), {4{32'hC0DE0000 + 32'(i)}}, 1'b0, 1'b0, '0);
        end

        $display("[TB] lone core write");
        applyStimulus("t2", 1'b1, 1'b1, 13'h010, {16{8'hA5}}, 1'b0, 1'b0, '0);
        checkOutput("t2_gnt_const",  128'(core_gnt), 128'(1));
        checkOutput("t2_we_const",   128'(mem_we),   128'(1));
        checkOutput("t2_addr_const", 128'(mem_addr), 128'h010);

        $display("[TB] async reset during a locked host burst");
        applyStimulus("t1a", 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 13'd1);
        applyStimulus("t1b", 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 13'd2);
        applyStimulus("t1c", 1'b1, 1'b0, 13'd4, '0, 1'b1, 1'b1, 13'd3);
        #2 reset = 1'b1;
        #1 checkResetOutputs("t1_async");
        @(negedge clk);
        checkResetOutputs("t1_held");
        core_req = 1'b0; host_req = 1'b0; host_lock = 1'b0;
        reset = 1'b0;
        modelReset();

        $display("[TB] round robin with both requesters");
        for (int k = 0; k < 4; k++) begin
            applyStimulus("t3", 1'b1, 1'b0, 13'd1, '0, 1'b1, 1'b0, 13'd2);
            checkOutput("t3_core_order", 128'(core_gnt), 128'(k % 2 == 0));
            checkOutput("t3_host_order", 128'(host_gnt), 128'(k % 2 == 1));
            if (k > 0) checkOutput("t3_core_rvalid_lag", 128'(core_rvalid), 128'(k % 2 == 1));
        end
        applyStimulus("t3e", 1'b1, 1'b0, 13'd6, '0, 1'b0, 1'b0, '0);
        checkOutput("t3_host_rvalid_lag", 128'(host_rvalid), 128'(1));
        applyStimulus("idle", 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);

        $display("[TB] twelve-beat locked host burst");
        remaining  = 12;
        hostGrants = 0;
        for (int k = 0; k < 30 && remaining > 0; k++) begin
            applyStimulus("t4", 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 13'(12 - remaining));
            if (k < 8) checkOutput("t4_beat", 128'(host_gnt), 128'(1));
            else if (k == 8) checkOutput("t4_gap", 128'(host_gnt), 128'(0));
            else if (k == 9) checkOutput("t4_regrant", 128'(host_gnt), 128'(1));
            if (host_gnt) hostGrants++;
            if (predHost) remaining--;
        end
        checkOutput("t4_total_grants", 128'(hostGrants), 128'(12));
        applyStimulus("idle", 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);

        $display("[TB] core arrives during a locked burst");
        applyStimulus("t5a", 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 13'd7);
        stallCount  = 0;
        coreGrantAt = -1;
        for (int k = 0; k < 10 && coreGrantAt < 0; k++) begin
            applyStimulus("t5", 1'b1, 1'b0, 13'd3, '0, 1'b1, 1'b1, 13'(k & 15));
            if (core_stall) stallCount++;
            if (core_gnt) coreGrantAt = k;
        end
        checkOutput("t5_stall_cycles", 128'(stallCount), 128'(MAX_WAIT));
        checkOutput("t5_gnt_cycle",    128'(coreGrantAt), 128'(MAX_WAIT));
        applyStimulus("t5r", 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 13'd8);
        checkOutput("t5_host_resume", 128'(host_gnt), 128'(1));

        $display("[TB] core write then host read of the same word");
        applyStimulus("t6w", 1'b1, 1'b1, 13'h005, 128'h1234, 1'b0, 1'b0, '0);
        applyStimulus("t6r", 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 13'h005);
        applyStimulus("t6d", 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
        checkOutput("t6_host_rvalid", 128'(host_rvalid), 128'(1));
        checkOutput("t6_host_rdata",  host_rdata,        128'h1234);

        $display("[TB] random traffic");
        rCReq = 1'b0; rCWe = 1'b0; rCAddr = '0; rCWdata = '0;
        rHReq = 1'b0; rHLock = 1'b0; rHAddr = '0;
        for (int n = 0; n < 400; n++) begin
            if (!predStall) begin
                rCReq   = ($urandom_range(0, 99) < 55);
                rCWe    = $urandom_range(0, 1) == 1;
                rCAddr  = 13'($urandom_range(0, 15));
                rCWdata = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!(rHReq && !predHost)) begin
                rHReq  = ($urandom_range(0, 99) < 60);
                rHAddr = 13'($urandom_range(0, 15));
            end
            rHLock = ($urandom_range(0, 99) < 70);
            applyStimulus("rnd", rCReq, rCWe, rCAddr, rCWdata, rHReq, rHLock, rHAddr);
        end
        applyStimulus("drain", 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
        applyStimulus("drain", 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
